// File: rtl/cwt_fft_pkg.sv
// Shared constants, FSM state type and twiddle addressing helper for the CWT FFT sequencer.
package cwt_fft_pkg;

    localparam int FFT_LOG2N = 4;
    localparam int FFT_N     = 1 << FFT_LOG2N;
    localparam int STAGE_W   = 3;
    // Twiddle words are signed Q8.8
    localparam int TW_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    // First twiddle ROM entry used by stage s; stages are packed back to back.
    function automatic logic [7:0] stage_base(input logic [STAGE_W-1:0] s);
        return 8'((9'd1 << s) - 9'd1);
    endfunction

endpackage

// File: rtl/fft_bfly_index_gen.sv
// Combinational map from (stage, butterfly) to operand indices and twiddle ROM address.
module fft_bfly_index_gen
    import cwt_fft_pkg::*;
#(
    parameter int LOG2N  = FFT_LOG2N,
    parameter int ADDR_W = 5
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]   cnt,
    output logic [LOG2N-1:0]   idx_a,
    output logic [LOG2N-1:0]   idx_b,
    output logic [ADDR_W-1:0]  rom_addr
);

    logic [LOG2N-1:0] c_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] j;
    logic [LOG2N-1:0] g;

    // Group g spans 2*half points; j is the offset inside the group and picks the twiddle.
    always_comb begin
        c_ext    = {1'b0, cnt};
        half     = LOG2N'(1) << stage;
        j        = c_ext & (half - LOG2N'(1));
        g        = c_ext >> stage;
        idx_a    = (g << (stage + STAGE_W'(1))) | j;
        idx_b    = idx_a | half;
        rom_addr = ADDR_W'(stage_base(stage)) + ADDR_W'(j);
    end

endmodule

// File: rtl/twiddle_fft_sequencer.sv
// Radix-2 DIT FFT pass sequencer: issues twiddle ROM reads one cycle ahead of butterfly operands.
// Optional abort input is compiled in when TW_SEQ_ABORT_EN is defined.
module twiddle_fft_sequencer
    import cwt_fft_pkg::*;
#(
    parameter int LOG2N     = FFT_LOG2N,
    parameter int ADDR_W    = 5,
    parameter int DRAIN_CYC = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               bf_ready,
`ifdef TW_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               bf_valid,
    output logic [LOG2N-1:0]   bf_idx_a,
    output logic [LOG2N-1:0]   bf_idx_b,
    output logic [STAGE_W-1:0] bf_stage,
    output logic               bf_last,
    output logic               busy,
    output logic               done
);

    localparam int CW = LOG2N - 1;
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CW-1:0]      C_LAST = '1;
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);

    seq_state_e         state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic               bf_valid_q, bf_valid_d;
    logic [LOG2N-1:0]   bf_idx_a_q, bf_idx_a_d;
    logic [LOG2N-1:0]   bf_idx_b_q, bf_idx_b_d;
    logic [STAGE_W-1:0] bf_stage_q, bf_stage_d;
    logic               bf_last_q, bf_last_d;
    logic               load;
    logic               abort_req;
    logic [LOG2N-1:0]   gen_a, gen_b;
    logic [ADDR_W-1:0]  gen_addr;

`ifdef TW_SEQ_ABORT_EN
    assign abort_req = abort && (state_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    fft_bfly_index_gen #(
        .LOG2N  (LOG2N),
        .ADDR_W (ADDR_W)
    ) u_index_gen (
        .stage    (stage_d),
        .cnt      (cnt_d),
        .idx_a    (gen_a),
        .idx_b    (gen_b),
        .rom_addr (gen_addr)
    );

    // 'load' marks the cycle a butterfly's ROM address goes out; its operands appear next cycle.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        bf_valid_d = bf_valid_q;
        load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (bf_ready) begin
                    if (cnt_q == C_LAST) begin
                        state_d    = DRAIN;
                        drain_d    = '0;
                        bf_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        load  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DW'(DRAIN_CYC - 1)) begin
                    if (stage_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + STAGE_W'(1);
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            bf_valid_d = 1'b1;
        end

        if (abort_req) begin
            state_d    = IDLE;
            stage_d    = stage_q;
            cnt_d      = cnt_q;
            load       = 1'b0;
            bf_valid_d = 1'b0;
        end

        bf_idx_a_d = load ? gen_a : bf_idx_a_q;
        bf_idx_b_d = load ? gen_b : bf_idx_b_q;
        bf_stage_d = load ? stage_d : bf_stage_q;
        bf_last_d  = bf_valid_d ? bf_last_q : 1'b0;
        if (load) begin
            bf_last_d = (stage_d == S_LAST) && (cnt_d == C_LAST);
        end
    end

    // While stalled the previous address is replayed so the ROM output stays put.
    assign rom_addr = load ? gen_addr : rom_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            rom_addr_q <= '0;
            bf_valid_q <= 1'b0;
            bf_idx_a_q <= '0;
            bf_idx_b_q <= '0;
            bf_stage_q <= '0;
            bf_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            rom_addr_q <= rom_addr;
            bf_valid_q <= bf_valid_d;
            bf_idx_a_q <= bf_idx_a_d;
            bf_idx_b_q <= bf_idx_b_d;
            bf_stage_q <= bf_stage_d;
            bf_last_q  <= bf_last_d;
        end
    end

    assign bf_valid = bf_valid_q;
    assign bf_idx_a = bf_idx_a_q;
    assign bf_idx_b = bf_idx_b_q;
    assign bf_stage = bf_stage_q;
    assign bf_last  = bf_last_q;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_twiddle_fft_sequencer.sv
// Scoreboard bench for twiddle_fft_sequencer with a registered twiddle ROM model attached.
// Abort scenario is included when TW_SEQ_ABORT_EN is defined.
module tb_twiddle_fft_sequencer;
    import cwt_fft_pkg::*;

    localparam int LOG2N     = 4;
    localparam int ADDR_W    = 5;
    localparam int DRAIN_CYC = 3;
    localparam int NPTS      = 1 << LOG2N;
    localparam int BEATS     = (NPTS / 2) * LOG2N;
    localparam int PASS_CYC  = BEATS + LOG2N * DRAIN_CYC + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bf_ready = 1'b1;
`ifdef TW_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif
    logic [ADDR_W-1:0]  rom_addr;
    logic               bf_valid;
    logic [LOG2N-1:0]   bf_idx_a;
    logic [LOG2N-1:0]   bf_idx_b;
    logic [STAGE_W-1:0] bf_stage;
    logic               bf_last;
    logic               busy;
    logic               done;
    logic [TW_W-1:0]    rom_data;

    typedef struct packed {
        logic [LOG2N-1:0]   a;
        logic [LOG2N-1:0]   b;
        logic [STAGE_W-1:0] s;
        logic               last;
        logic [TW_W-1:0]    tw;
    } beat_t;

    beat_t expQ[$];
    beat_t monExp;
    int vectors = 0;
    int miscompares = 0;
    int beatCnt = 0, lastCnt = 0, doneCnt = 0, gapCnt = 0, strayCnt = 0;
    int cycleNo = 0;
    int startCyc = 0;
    int passLen = 0;
    bit found;

    twiddle_fft_sequencer #(
        .LOG2N     (LOG2N),
        .ADDR_W    (ADDR_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bf_ready (bf_ready),
`ifdef TW_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .rom_addr (rom_addr),
        .bf_valid (bf_valid),
        .bf_idx_a (bf_idx_a),
        .bf_idx_b (bf_idx_b),
        .bf_stage (bf_stage),
        .bf_last  (bf_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Distinct word per ROM entry so a misaligned read is visible
    function automatic logic [TW_W-1:0] romWord(input int addr);
        return TW_W'(32'h3A00 + addr * 97);
    endfunction

    always @(posedge clk) rom_data <= romWord(int'(rom_addr));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference ordering: per stage, walk groups of 2*half points, offset j inside each group
    task automatic pushPass();
        for (int s = 0; s < LOG2N; s++) begin
            int half;
            int groups;
            half   = 2 ** s;
            groups = NPTS / (2 * half);
            for (int g = 0; g < groups; g++) begin
                for (int j = 0; j < half; j++) begin
                    beat_t e;
                    e.a    = LOG2N'(g * 2 * half + j);
                    e.b    = LOG2N'(g * 2 * half + j + half);
                    e.s    = STAGE_W'(s);
                    e.last = (s == LOG2N - 1) && (g == groups - 1) && (j == half - 1);
                    e.tw   = romWord((2 ** s) - 1 + j);
                    expQ.push_back(e);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bf_valid && bf_ready) begin
                beatCnt++;
                if (bf_last) lastCnt++;
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat", 32'd1, 32'd0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("idx_a", 32'(bf_idx_a), 32'(monExp.a));
                    checkOutput("idx_b", 32'(bf_idx_b), 32'(monExp.b));
                    checkOutput("stage", 32'(bf_stage), 32'(monExp.s));
                    checkOutput("last", 32'(bf_last), 32'(monExp.last));
                    checkOutput("rom_data", 32'(rom_data), 32'(monExp.tw));
                end
            end
            if (busy && !bf_valid) gapCnt++;
            if (bf_valid && !busy) strayCnt++;
            if (done) doneCnt++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetCounters();
        beatCnt  = 0;
        lastCnt  = 0;
        doneCnt  = 0;
        gapCnt   = 0;
        strayCnt = 0;
    endtask

    // Pulse start for one cycle and queue the full expected pass
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        start    = 1'b1;
        startCyc = cycleNo;
        pushPass();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int k;
        k = 0;
        while (!done && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
        passLen = cycleNo - startCyc + 1;
    endtask

    task automatic waitBeat(input int s, input int a, output bit hit);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (bf_valid && bf_stage == STAGE_W'(s) && bf_idx_a == LOG2N'(a)) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        checkOutput({tag, "_bf_valid"}, 32'(bf_valid), 32'd0);
        checkOutput({tag, "_idx_a"}, 32'(bf_idx_a), 32'd0);
        checkOutput({tag, "_idx_b"}, 32'(bf_idx_b), 32'd0);
        checkOutput({tag, "_stage"}, 32'(bf_stage), 32'd0);
        checkOutput({tag, "_last"}, 32'(bf_last), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic checkPassCounts(input string tag);
        checkOutput({tag, "_beats"}, 32'(beatCnt), 32'(BEATS));
        checkOutput({tag, "_last_count"}, 32'(lastCnt), 32'd1);
        checkOutput({tag, "_done_count"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, "_drain_cycles"}, 32'(gapCnt), 32'(LOG2N * DRAIN_CYC));
        checkOutput({tag, "_valid_outside_busy"}, 32'(strayCnt), 32'd0);
        checkOutput({tag, "_queue_left"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with start held high, then a pass interrupted by reset
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        resetCounters();
        applyStimulus();
        waitCycles(10);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checkResetOutputs("midrun");
        waitCycles(2);
        rst_n = 1'b1;
        start = 1'b0;
        expQ.delete();
        waitCycles(2);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        // Full pass with the butterfly unit always ready
        resetCounters();
        applyStimulus();
        waitDone("full");
        checkOutput("full_cycles", 32'(passLen), 32'(PASS_CYC));
        waitCycles(2);
        checkPassCounts("full");

        // Four-cycle stall on stage 2, butterfly 3
        resetCounters();
        applyStimulus();
        waitBeat(2, 3, found);
        checkOutput("stall_sync", 32'(found), 32'd1);
        bf_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(bf_valid), 32'd1);
            checkOutput("stall_idx_a", 32'(bf_idx_a), 32'd3);
            checkOutput("stall_idx_b", 32'(bf_idx_b), 32'd7);
            checkOutput("stall_rom_addr", 32'(rom_addr), 32'd6);
            @(posedge clk);
            #1;
        end
        bf_ready = 1'b1;
        waitDone("stall");
        checkOutput("stall_cycles", 32'(passLen), 32'(PASS_CYC + 4));
        waitCycles(2);
        checkPassCounts("stall");

        // start while busy and on the done cycle must not launch another pass
        resetCounters();
        applyStimulus();
        waitCycles(5);
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        waitDone("coll");
        checkOutput("coll_cycles", 32'(passLen), 32'(PASS_CYC));
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        waitCycles(20);
        checkOutput("coll_busy_after", 32'(busy), 32'd0);
        checkPassCounts("coll");

`ifdef TW_SEQ_ABORT_EN
        // Abort during the drain after stage 1, then a clean pass
        resetCounters();
        applyStimulus();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (busy && !bf_valid && bf_stage == STAGE_W'(1)) found = 1'b1;
            else waitCycles(1);
        end
        checkOutput("abort_sync", 32'(found), 32'd1);
        abort = 1'b1;
        waitCycles(1);
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(bf_valid), 32'd0);
        waitCycles(5);
        checkOutput("abort_done_count", 32'(doneCnt), 32'd0);
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);
        expQ.delete();

        resetCounters();
        applyStimulus();
        waitDone("after_abort");
        checkOutput("after_abort_cycles", 32'(passLen), 32'(PASS_CYC));
        waitCycles(2);
        checkPassCounts("after_abort");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
